pipe_gap_arbiter: RTL

//  Shares one 10-bit XNOR LFSR between NREQ pipe spawners.

---
 rtl/pipe_gap_pkg.sv | 16 +
 rtl/lfsr_step.sv | 19 +
 rtl/pipe_gap_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/pipe_gap_pkg.sv
// Shared types and constants for the pipe gap arbiter.
// The LFSR taps and reset value live here so the stepper and top agree.
package pipe_gap_pkg;
  localparam int LFSR_W = 10;
  localparam int TAP_HI = 3;
  localparam int TAP_LO = 0;
  localparam logic [LFSR_W-1:0] LFSR_RESET = '0;

  typedef enum logic [2:0] {
    IDLE,
    DRAW,
    LOAD,
    REDUCE,
    DONE
  } state_t;
endpackage

// File: rtl/lfsr_step.sv
// 10-bit XNOR LFSR advanced one step per enabled cycle.
// All-ones is the lock state and cannot be reached from reset.
module lfsr_step
  import pipe_gap_pkg::*;
(
  input  logic              Clock,
  input  logic              RST,
  input  logic              en,
  output logic [LFSR_W-1:0] out
);

  always_ff @(posedge Clock) begin
    if (RST)
      out <= LFSR_RESET;
    else if (en)
      out <= {~(out[TAP_HI] ^ out[TAP_LO]), out[LFSR_W-1:1]};
  end

endmodule

// File: rtl/pipe_gap_arbiter.sv
// Round-robin arbiter sharing one LFSR between pipe spawners.
// Each grant draws SHIFTS steps and reduces the value to a gap row.
module pipe_gap_arbiter
  import pipe_gap_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int SHIFTS    = 4,
  parameter int GAP_MIN   = 2,
  parameter int GAP_RANGE = 10,
  parameter int GW        = 4
) (
  input  logic            Clock,
  input  logic            RST,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] done,
  output logic [GW-1:0]   gap,
  output logic            busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(SHIFTS + 1);
  localparam logic [LFSR_W-1:0] RANGE = LFSR_W'(GAP_RANGE);

  if (GAP_MIN + GAP_RANGE - 1 >= 2 ** GW) begin : g_gw_check
    $error("GW too narrow for the gap range");
  end
  if (SHIFTS < 1 || GAP_RANGE < 1) begin : g_par_check
    $error("SHIFTS and GAP_RANGE must be at least 1");
  end

  state_t            state, state_nxt;
  logic [PW-1:0]     ptr, ptr_nxt;
  logic [PW-1:0]     winner, winner_nxt;
  logic [PW-1:0]     pick;
  logic              pick_ok;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [LFSR_W-1:0] rem, rem_nxt;
  logic [LFSR_W-1:0] lfsr;
  logic              lfsr_en;
  logic [NREQ-1:0]   done_nxt;
  logic [GW-1:0]     gap_nxt;

  lfsr_step u_lfsr (
    .Clock (Clock),
    .RST   (RST),
    .en    (lfsr_en),
    .out   (lfsr)
  );

  assign busy = (state != IDLE);

  // First requester after the last winner gets the grant.
  always_comb begin
    pick_ok = 1'b0;
    pick    = '0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!pick_ok && req[PW'((int'(ptr) + i) % NREQ)]) begin
        pick_ok = 1'b1;
        pick    = PW'((int'(ptr) + i) % NREQ);
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    winner_nxt = winner;
    cnt_nxt    = cnt;
    rem_nxt    = rem;
    done_nxt   = '0;
    gap_nxt    = gap;
    lfsr_en    = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_ok) begin
          winner_nxt = pick;
          ptr_nxt    = pick;
          cnt_nxt    = '0;
          state_nxt  = DRAW;
        end
      end
      DRAW: begin
        lfsr_en = 1'b1;
        cnt_nxt = cnt + 1'b1;
        if (cnt == CW'(SHIFTS - 1))
          state_nxt = LOAD;
      end
      LOAD: begin
        rem_nxt   = lfsr;
        state_nxt = REDUCE;
      end
      REDUCE: begin
        // compare before subtract keeps rem from wrapping
        if (rem >= RANGE) begin
          rem_nxt = rem - RANGE;
        end else begin
          gap_nxt          = GW'(GAP_MIN) + GW'(rem);
          done_nxt[winner] = 1'b1;
          state_nxt        = DONE;
        end
      end
      DONE: begin
        gap_nxt   = '0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (RST) begin
      state  <= IDLE;
      ptr    <= PW'(NREQ - 1);
      winner <= '0;
      cnt    <= '0;
      rem    <= '0;
      done   <= '0;
      gap    <= '0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      winner <= winner_nxt;
      cnt    <= cnt_nxt;
      rem    <= rem_nxt;
      done   <= done_nxt;
      gap    <= gap_nxt;
    end
  end

endmodule
